// File: rtl/bin2bcd_if.sv
// bin2bcd_if: start/busy/done handshake and result bus of the binary-to-BCD converter
interface bin2bcd_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
  modport master (output start, bin_in, input busy, done, bcd_out, overflow);
  modport slave  (input start, bin_in, output busy, done, bcd_out, overflow);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-clock double-dabble converter; BIN2BCD_ZERO_BLANK_EN blanks leading zeros with 4'hF
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input logic       clk,
  input logic       rst,
  bin2bcd_if.slave  bus
);
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t              state;
  logic [BIN_W-1:0]    sr;
  logic [4*DIGITS-1:0] dig, adj, nxt_dig, res, bcd_q;
  logic [CW-1:0]       cnt;
  logic                sticky, top, done_q, ovf_q;
  // Correct every digit >=5, then shift the next input bit into digit 0
  always_comb begin
    adj = dig;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = dig[4*i +: 4] >= 4'd5 ? dig[4*i +: 4] + 4'd3 : dig[4*i +: 4];
    top = adj[4*DIGITS-1];
    nxt_dig = DIGITS > 0 ? {adj[4*DIGITS-2:0], sr[BIN_W-1]} : '0;
  end
`ifdef BIN2BCD_ZERO_BLANK_EN
  logic lead;
  // Replace leading zero digits above digit 0 with the display blank code
  always_comb begin
    res = nxt_dig;
    lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      lead = lead && nxt_dig[4*i +: 4] == 4'd0;
      res[4*i +: 4] = lead ? 4'hF : nxt_dig[4*i +: 4];
    end
  end
`else
  assign res = nxt_dig;
`endif
  // Control FSM with working registers and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sr     <= '0;
      dig    <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
      done_q <= 1'b0;
      bcd_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          sr     <= bus.bin_in;
          dig    <= '0;
          sticky <= 1'b0;
          cnt    <= CW'(BIN_W);
          state  <= SHIFT;
        end
        SHIFT: begin
          sr     <= sr << 1;
          dig    <= nxt_dig;
          sticky <= sticky | top;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd_q  <= (sticky | top) ? {DIGITS{4'h9}} : res;
            ovf_q  <= sticky | top;
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.busy     = state == SHIFT;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed table-driven bench running a 3-digit and a 2-digit converter side by side
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] bin_in = '0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  bin2bcd_if #(.BIN_W(8), .DIGITS(3)) b3 ();
  bin2bcd_if #(.BIN_W(8), .DIGITS(2)) b2 ();
  assign b3.start = start;
  assign b3.bin_in = bin_in;
  assign b2.start = start;
  assign b2.bin_in = bin_in;
  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u3 (.clk(clk), .rst(rst), .bus(b3));
  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u2 (.clk(clk), .rst(rst), .bus(b2));

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd3;
    logic        ovf3;
    logic [7:0]  bcd2;
    logic        ovf2;
  } vec_t;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] fmt(input logic [39:0] v, input int d, input logic ovf);
    logic [39:0] r;
    r = v;
`ifdef BIN2BCD_ZERO_BLANK_EN
    if (!ovf)
      for (int i = d - 1; i > 0; i--) begin
        if (r[4*i +: 4] != 4'd0) break;
        r[4*i +: 4] = 4'hF;
      end
`endif
    return r;
  endfunction

  task automatic check_result(input string tag, input vec_t v);
    chk({tag, " bcd3"}, 40'(b3.bcd_out), fmt(40'(v.bcd3), 3, v.ovf3));
    chk({tag, " ovf3"}, 40'(b3.overflow), 40'(v.ovf3));
    chk({tag, " bcd2"}, 40'(b2.bcd_out), fmt(40'(v.bcd2), 2, v.ovf2));
    chk({tag, " ovf2"}, 40'(b2.overflow), 40'(v.ovf2));
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!b3.done && n < 20);
    chk({tag, " latency"}, 40'(n), 40'd8);
    chk({tag, " done2"}, 40'(b2.done), 40'd1);
  endtask

  vec_t tbl[8];
  int n;
  int dones;

  initial begin
    tbl[0] = '{8'd255, 12'h255, 1'b0, 8'h99, 1'b1};
    tbl[1] = '{8'd100, 12'h100, 1'b0, 8'h99, 1'b1};
    tbl[2] = '{8'd99,  12'h099, 1'b0, 8'h99, 1'b0};
    tbl[3] = '{8'd0,   12'h000, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'd7,   12'h007, 1'b0, 8'h07, 1'b0};
    tbl[5] = '{8'd128, 12'h128, 1'b0, 8'h99, 1'b1};
    tbl[6] = '{8'd9,   12'h009, 1'b0, 8'h09, 1'b0};
    tbl[7] = '{8'd10,  12'h010, 1'b0, 8'h10, 1'b0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset busy", 40'(b3.busy), 40'd0);
    chk("reset done", 40'(b3.done), 40'd0);
    chk("reset bcd", 40'(b3.bcd_out), 40'd0);
    chk("reset ovf", 40'(b3.overflow), 40'd0);
    for (int i = 0; i < 8; i++) begin
      start = 1'b1;
      bin_in = tbl[i].bin;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      bin_in = 8'hA5;
      chk("busy after start", 40'(b3.busy), 40'd1);
      wait_done($sformatf("vec%0d", i), n);
      chk("busy at done", 40'(b3.busy), 40'd0);
      check_result($sformatf("vec%0d", i), tbl[i]);
      @(posedge clk);
      @(negedge clk);
      chk("done one cycle", 40'(b3.done), 40'd0);
      check_result($sformatf("vec%0d hold", i), tbl[i]);
    end
    // restart attempt mid-conversion is ignored
    start = 1'b1;
    bin_in = 8'd42;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        start = 1'b1;
        bin_in = 8'd17;
      end else start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (b3.done) begin
        dones++;
        check_result("ignore", '{8'd42, 12'h042, 1'b0, 8'h42, 1'b0});
      end
    end
    chk("ignore dones", 40'(dones), 40'd1);
    chk("ignore idle", 40'(b3.busy), 40'd0);
    // reset in the middle of a conversion
    start = 1'b1;
    bin_in = 8'd200;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 40'(b3.busy), 40'd0);
    chk("abort bcd", 40'(b3.bcd_out), 40'd0);
    chk("abort ovf", 40'(b2.overflow), 40'd0);
    dones = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (b3.done || b2.done) dones++;
    end
    chk("abort no done", 40'(dones), 40'd0);
    start = 1'b1;
    bin_in = 8'd200;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done("fresh", n);
    check_result("fresh", '{8'd200, 12'h200, 1'b0, 8'h99, 1'b1});
    @(posedge clk);
    @(negedge clk);
    // back-to-back with start held high, values alternating 59/60
    start = 1'b1;
    bin_in = 8'd59;
    @(posedge clk);
    @(negedge clk);
    bin_in = 8'd60;
    for (int j = 0; j < 4; j++) begin
      wait_done($sformatf("b2b%0d", j), n);
      if (j % 2 == 0) check_result($sformatf("b2b%0d", j), '{8'd59, 12'h059, 1'b0, 8'h59, 1'b0});
      else check_result($sformatf("b2b%0d", j), '{8'd60, 12'h060, 1'b0, 8'h60, 1'b0});
      @(posedge clk);
      @(negedge clk);
      chk("b2b done pulse", 40'(b3.done), 40'd0);
      chk("b2b busy", 40'(b3.busy), 40'd1);
      bin_in = (j % 2 == 0) ? 8'd59 : 8'd60;
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
